// File: rtl/store_buffer_if.sv
// Bundles the store, memory-write and load-forwarding signals of the store buffer.
// The master drives requests and acknowledges; the slave is the buffer itself.
interface store_buffer_if;
  logic        stValid;
  logic [29:0] stAddr;
  logic [31:0] stData;
  logic [3:0]  stEn;
  logic        stReady;

  logic        memReq;
  logic [29:0] memAddr;
  logic [31:0] memData;
  logic [3:0]  memEnable;
  logic        memAck;

  logic [29:0] ldAddr;
  logic [3:0]  ldHitMask;
  logic [31:0] ldData;

  modport master (
    output stValid, stAddr, stData, stEn, memAck, ldAddr,
    input  stReady, memReq, memAddr, memData, memEnable, ldHitMask, ldData
  );

  modport slave (
    input  stValid, stAddr, stData, stEn, memAck, ldAddr,
    output stReady, memReq, memAddr, memData, memEnable, ldHitMask, ldData
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: queues byte-enabled word stores, drains them to memory
// head-first, merges stores to the youngest entry's word and forwards to loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  store_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  en;
  } entry_t;

  entry_t entries [DEPTH];
  ptr_t   head, tail, tail_last;
  cnt_t   count;

  logic        full, st_act, coal_ok, do_coal, do_push, do_pop;
  logic [31:0] merged;
  logic [3:0]  hit;
  logic [31:0] fwd;

  assign tail_last = tail - ptr_t'(1);
  assign full      = (count == cnt_t'(DEPTH));
  assign st_act    = bus.stValid && (bus.stEn != 4'b0000);
  // With two or more entries the tail is never the head, so merging cannot disturb
  // the word currently offered to memory.
  assign coal_ok   = (count >= cnt_t'(2)) && (bus.stAddr == entries[tail_last].addr);
  assign do_coal   = st_act && coal_ok;
  assign do_push   = st_act && !coal_ok && !full;
  assign do_pop    = (count != '0) && bus.memAck;

  assign bus.stReady   = !full || coal_ok;
  assign bus.memReq    = (count != '0);
  assign bus.memAddr   = bus.memReq ? entries[head].addr : '0;
  assign bus.memData   = bus.memReq ? entries[head].data : '0;
  assign bus.memEnable = bus.memReq ? entries[head].en   : '0;

  // Lane i of the enable mask covers data[31-8i -: 8].
  always_comb begin
    merged = entries[tail_last].data;
    for (int j = 0; j < 4; j++)
      if (bus.stEn[j]) merged[31-8*j -: 8] = bus.stData[31-8*j -: 8];
  end

  // Walk oldest to youngest so younger matching lanes overwrite older ones.
  always_comb begin
    ptr_t idx;
    idx = head;
    hit = '0;
    fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + ptr_t'(i);
      if ((cnt_t'(i) < count) && (entries[idx].addr == bus.ldAddr)) begin
        for (int j = 0; j < 4; j++) begin
          if (entries[idx].en[j]) begin
            hit[j]             = 1'b1;
            fwd[31-8*j -: 8]   = entries[idx].data[31-8*j -: 8];
          end
        end
      end
    end
  end

  assign bus.ldHitMask = hit;
  assign bus.ldData    = fwd;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the entry array is cleared on reset as well, so a reset
  // buffer carries no stale store data.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (do_push) begin
        entries[tail] <= '{addr: bus.stAddr, data: bus.stData, en: bus.stEn};
        tail          <= tail + ptr_t'(1);
      end
      if (do_coal) begin
        entries[tail_last].data <= merged;
        entries[tail_last].en   <= entries[tail_last].en | bus.stEn;
      end
      if (do_pop) head <= head + ptr_t'(1);
      count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a reference queue of expected memory writes is
// filled as stores are driven and compared when the buffer hands a write to memory.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  en;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] e, input logic ack);
    bus.stValid = v;
    bus.stAddr  = a;
    bus.stData  = d;
    bus.stEn    = e;
    bus.memAck  = ack;
  endtask

  // Checks handshake outputs against the reference queue, retires a memory write if
  // one is acknowledged, records the store this cycle, then advances one clock.
  task automatic cycle();
    int   sz;
    logic coal;
    ent_t e;
    #1;
    sz   = q.size();
    coal = 1'b0;
    if (sz >= 2) coal = (bus.stAddr == q[sz-1].addr);
    check("stReady", bus.stReady, (sz < DEPTH) || coal);
    check("memReq", bus.memReq, sz > 0);
    if (sz == 0) check("idle_bus", {bus.memAddr, bus.memData, bus.memEnable}, 0);
    if (rst) begin
      q.delete();
    end else begin
      if (sz > 0 && bus.memAck) begin
        e = q.pop_front();
        check("mem_write", {bus.memAddr, bus.memData, bus.memEnable}, {e.addr, e.data, e.en});
      end
      if (bus.stValid && bus.stEn != 4'b0000) begin
        if (coal) begin
          e = q[q.size()-1];
          for (int j = 0; j < 4; j++)
            if (bus.stEn[j]) e.data[31-8*j -: 8] = bus.stData[31-8*j -: 8];
          e.en = e.en | bus.stEn;
          q[q.size()-1] = e;
        end else if (sz < DEPTH) begin
          q.push_back('{bus.stAddr, bus.stData, bus.stEn});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [29:0] a, input logic [31:0] d, input logic [3:0] e);
    drive(1'b1, a, d, e, 1'b0);
    cycle();
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
    #1;
    check("drain_memReq", bus.memReq, 1'b0);
    bus.memAck = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    bus.ldAddr = '0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_memReq", bus.memReq, 1'b0);
    check("rst_stReady", bus.stReady, 1'b1);
    check("rst_ldHitMask", bus.ldHitMask, 4'b0000);
    check("rst_ldData", bus.ldData, 32'h0);
    check("rst_bus", {bus.memAddr, bus.memData, bus.memEnable}, 0);

    // Single store, acknowledged the cycle after it appears.
    store(30'h10, 32'hAB00_0000, 4'b0001);
    #1;
    check("single_addr", bus.memAddr, 30'h10);
    check("single_en", bus.memEnable, 4'b0001);
    drive(1'b0, '0, '0, '0, 1'b1);
    cycle();
    bus.memAck = 1'b0;
    cycle();

    // Zero byte enables are a no-op.
    drive(1'b1, 30'h11, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    cycle();
    cycle();

    // Fill to capacity, fifth store stalls until one entry drains.
    for (int k = 1; k <= 4; k++) store(30'(k), 32'h1000_0000 * k, 4'b1111);
    drive(1'b1, 30'h5, 32'h5555_5555, 4'b1111, 1'b0);
    #1;
    check("full_stReady", bus.stReady, 1'b0);
    cycle();
    drive(1'b1, 30'h5, 32'h5555_5555, 4'b1111, 1'b1);
    cycle();
    check("after_pop_stReady", bus.stReady, 1'b1);
    drive(1'b1, 30'h5, 32'h5555_5555, 4'b1111, 1'b0);
    cycle();
    drain();

    // Merge into the youngest entry while the head stays untouched.
    store(30'h7, 32'h0000_BEEF, 4'b1100);
    store(30'h9, 32'h0000_BEEF, 4'b1100);
    store(30'h9, 32'hCAFE_0000, 4'b0011);
    drive(1'b0, '0, '0, '0, 1'b0);
    bus.ldAddr = 30'h9;
    #1;
    check("coal_tail_mask", bus.ldHitMask, 4'b1111);
    check("coal_tail_data", bus.ldData, 32'hCAFE_BEEF);
    check("coal_head_addr", bus.memAddr, 30'h7);
    check("coal_head_en", bus.memEnable, 4'b1100);
    check("coal_head_data", bus.memData, 32'h0000_BEEF);
    bus.ldAddr = 30'h7;
    #1;
    check("coal_head_fwd", bus.ldHitMask, 4'b1100);
    cycle();
    drain();

    // Merge is still accepted while full.
    for (int k = 0; k < 4; k++) store(30'h40 + 30'(k), 32'hA0A0_A0A0 + k, 4'b0101);
    drive(1'b1, 30'h43, 32'h1234_5678, 4'b1010, 1'b0);
    #1;
    check("full_coal_stReady", bus.stReady, 1'b1);
    cycle();
    drain();

    // A single-entry buffer never merges into its head; both lanes forward.
    store(30'h3, 32'h1100_0000, 4'b0001);
    store(30'h3, 32'h0000_0022, 4'b1000);
    drive(1'b0, '0, '0, '0, 1'b0);
    bus.ldAddr = 30'h3;
    #1;
    check("fwd_mask", bus.ldHitMask, 4'b1001);
    check("fwd_data", bus.ldData, 32'h1100_0022);
    bus.ldAddr = 30'h4;
    #1;
    check("fwd_miss_mask", bus.ldHitMask, 4'b0000);
    check("fwd_miss_data", bus.ldData, 32'h0);
    drain();

    // Push and pop together at two entries, across a pointer wrap.
    store(30'h20, 32'h2020_2020, 4'b1111);
    store(30'h21, 32'h2121_2121, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 30'h30 + 30'(k), $urandom, 4'b1111, 1'b1);
      cycle();
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    #1;
    check("wrap_head_addr", bus.memAddr, 30'h36);
    drain();

    // Reset mid-operation wins over a simultaneous store and acknowledge.
    for (int k = 0; k < 3; k++) store(30'h50 + 30'(k), 32'h5050_0000 + k, 4'b1111);
    rst = 1'b1;
    drive(1'b1, 30'h53, 32'h5353_5353, 4'b1111, 1'b1);
    bus.ldAddr = 30'h50;
    cycle();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    #1;
    check("midrst_memReq", bus.memReq, 1'b0);
    check("midrst_ldHitMask", bus.ldHitMask, 4'b0000);
    check("midrst_stReady", bus.stReady, 1'b1);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, >=2), number of buffered store entries.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stValid  input  1  store request from the write-data encoder stage (its memWrite qualifier).
REQ-005 SHALL have port stAddr  input  30  word address, physical address bits [31:2].
REQ-006 SHALL have port stData  input  32  lane-aligned write data from the encoder.
REQ-007 SHALL have port stEn  input  4  byte enables from the encoder; bit i qualifies lane data[31-8i:24-8i].
REQ-008 SHALL have port stReady  output  1  buffer can accept stValid this cycle.
REQ-009 SHALL have port memReq  output  1  write request to data memory.
REQ-010 SHALL have port memAddr  output  30  word address of the head entry.
REQ-011 SHALL have port memData  output  32  data of the head entry.
REQ-012 SHALL have port memEnable  output  4  byte enables of the head entry (same lane mapping as stEn).
REQ-013 SHALL have port memAck  input  1  memory accepted the presented write this cycle.
REQ-014 SHALL have port ldAddr  input  30  word address of an in-flight load, for forwarding lookup.
REQ-015 SHALL have port ldHitMask  output  4  per-lane: buffered data exists for ldAddr.
REQ-016 SHALL have port ldData  output  32  forwarded lanes; lanes with ldHitMask=0 read 0.

Function
REQ-017 SHALL hold up to DEPTH entries {addr, data, en} in FIFO order with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-018 SHALL treat a store with stValid=1 and stEn=4'b0000 as a no-op (no push, no merge); stReady is unaffected.
REQ-019 SHALL accept (push) a store when stValid=1, stEn!=0, stReady=1; entry written at the clock edge.
REQ-020 SHALL coalesce instead of push when count>=2 and stAddr equals the tail (youngest) entry address: lanes with stEn=1 overwrite tail data, tail en becomes en|stEn, count unchanged.
REQ-021 SHALL never coalesce into the head entry (head is being presented to memory).
REQ-022 SHALL drive stReady = (count<DEPTH) OR (coalesce condition of REQ-020 true); combinational.
REQ-023 SHALL drive memReq=1 iff count>0; memAddr/memData/memEnable equal the head entry fields and remain stable while memReq=1 and memAck=0.
REQ-024 SHALL pop the head at a clock edge where memReq=1 and memAck=1; memAck while memReq=0 is ignored.
REQ-025 SHALL support push and pop in the same cycle (count unchanged), including at count=DEPTH only when coalescing (no push while full).
REQ-026 Latency: store pushed into an empty buffer at edge N SHALL present memReq=1 from cycle after edge N; memory never sees a store before it is in the buffer.
REQ-027 SHALL drive memAddr/memData/memEnable to 0 when count=0.
REQ-028 Forwarding: for each lane, ldData/ldHitMask SHALL take the youngest valid entry with addr=ldAddr and that lane enabled; combinational, uses registered state only (not same-cycle stValid).
REQ-029 SHALL treat the head entry as valid for forwarding until the edge at which it pops.

Reset
REQ-030 On rst=1 at a clock edge SHALL set count=0, head=tail=0, all entry fields 0; memReq=0, memAddr/memData/memEnable=0, stReady=1, ldHitMask=0, ldData=0.
REQ-031 rst SHALL take priority over simultaneous stValid and memAck; in-flight entries are discarded (mid-operation reset drops pending stores).

Verification
REQ-032 Single store: push addr=0x10, data=0xAB000000, en=0001 into empty buffer, memAck=1 next cycle -> memReq high one cycle with memAddr=0x10, memEnable=0001, count returns 0.
REQ-033 Fill/stall: memAck=0, push 4 stores to distinct addrs 1..4 -> stReady=0 after 4th; 5th store (addr 5) held off; memAck=1 once -> addr 1 pops, stReady=1.
REQ-034 Coalesce: push addr 7 en=1100 data=0x0000BEEF, then addr 9 en=1100, then addr 9 en=0011 data=0xCAFE0000 with memAck=0 -> count=2, tail en=1111, data=0xCAFEBEEF; head addr 7 untouched.
REQ-035 Forwarding: buffer holds addr 3 en=0001 data=0x11000000 then addr 3 en=1000 data=0x00000022 (count=1 for first, second pushes) -> ldAddr=3 gives ldHitMask=1001, ldData=0x11000022; ldAddr=4 gives 0000/0.
REQ-036 Simultaneous push/pop at count=2 with memAck=1 -> count stays 2, order preserved across pointer wrap after 8 such cycles.
REQ-037 Reset mid-operation: 3 entries pending, rst=1 with stValid=1 and memAck=1 -> next cycle count=0, memReq=0, ldHitMask=0.
